// File: rtl/fwd_clk_pattern_gen.sv
// D0/D1 pattern source for a DDR clock-forwarding output register.
// Emits a 50%-duty clock at clk/div with glitch-free start, stop and ratio changes.
module fwd_clk_pattern_gen #(
   parameter int   DIV_W    = 8,
   parameter int   DEF_DIV  = 1,
   parameter logic IDLE_VAL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic             d0,
   output logic             d1,
   output logic             running
);

   localparam int PW = DIV_W + 1;
   localparam int CW = DIV_W + 2;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   state_t           state_reg;
   logic [DIV_W-1:0] div_act_reg;
   logic [DIV_W-1:0] pend_reg;
   logic             pend_valid_reg;
   logic [PW-1:0]    p_reg;
   logic             d0_reg;
   logic             d1_reg;
   logic             running_reg;

   logic             xfer;
   logic             boundary;
   logic [PW-1:0]    p_adv;
   logic [DIV_W-1:0] cfg_norm;
   logic [DIV_W-1:0] div_next;

   // Pair for half-slot index p: high while the half-slot is inside the first div half-slots.
   function automatic logic [1:0] pair_at(input logic [PW-1:0] p, input logic [DIV_W-1:0] div);
      logic [CW-1:0] pe;
      logic [CW-1:0] de;
      pe = CW'(p);
      de = CW'(div);
      return {(pe < de), ((pe + CW'(1)) < de)};
   endfunction

   always_comb begin
      xfer     = cfg_valid & ~pend_valid_reg;
      boundary = ((CW'(p_reg) + CW'(2)) >= (CW'(div_act_reg) << 1));
      p_adv    = p_reg + PW'(2);
      cfg_norm = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
      div_next = pend_valid_reg ? pend_reg : div_act_reg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         div_act_reg    <= DIV_W'(DEF_DIV);
         pend_reg       <= DIV_W'(DEF_DIV);
         pend_valid_reg <= 1'b0;
         p_reg          <= '0;
         d0_reg         <= IDLE_VAL;
         d1_reg         <= IDLE_VAL;
         running_reg    <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               // A pending ratio is applied before any start, so the first period uses it.
               if (pend_valid_reg) begin
                  div_act_reg    <= pend_reg;
                  pend_valid_reg <= 1'b0;
               end else if (xfer) begin
                  pend_reg       <= cfg_norm;
                  pend_valid_reg <= 1'b1;
               end else if (enable) begin
                  state_reg        <= ST_RUN;
                  p_reg            <= '0;
                  {d0_reg, d1_reg} <= pair_at('0, div_act_reg);
                  running_reg      <= 1'b1;
               end
            end
            ST_RUN, ST_DRAIN: begin
               if (xfer) begin
                  pend_reg       <= cfg_norm;
                  pend_valid_reg <= 1'b1;
               end
               if (boundary) begin
                  if (pend_valid_reg) begin
                     div_act_reg    <= pend_reg;
                     pend_valid_reg <= 1'b0;
                  end
                  p_reg <= '0;
                  if (enable) begin
                     state_reg        <= ST_RUN;
                     {d0_reg, d1_reg} <= pair_at('0, div_next);
                  end else begin
                     state_reg   <= ST_IDLE;
                     d0_reg      <= IDLE_VAL;
                     d1_reg      <= IDLE_VAL;
                     running_reg <= 1'b0;
                  end
               end else begin
                  p_reg            <= p_adv;
                  {d0_reg, d1_reg} <= pair_at(p_adv, div_act_reg);
                  state_reg        <= enable ? ST_RUN : ST_DRAIN;
               end
            end
            default: begin
               state_reg   <= ST_IDLE;
               d0_reg      <= IDLE_VAL;
               d1_reg      <= IDLE_VAL;
               running_reg <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_ready = ~pend_valid_reg;
   assign d0        = d0_reg;
   assign d1        = d1_reg;
   assign running   = running_reg;

endmodule

// File: tb/tb_fwd_clk_pattern_gen.sv
// Bench for fwd_clk_pattern_gen: directed scenarios plus random traffic against a slot-level model.
module tb_fwd_clk_pattern_gen;

   localparam int   DIV_W    = 8;
   localparam int   DEF_DIV  = 1;
   localparam logic IDLE_VAL = 1'b0;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b0;
   logic [DIV_W-1:0] cfg_div = '0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic             d0;
   logic             d1;
   logic             running;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   // Model: a period is m_div clock slots; slot s carries half-slots 2s and 2s+1,
   // and a half-slot is high when its index is below m_div.
   int m_div;
   int m_pend;
   int m_slot;
   bit m_run;
   bit m_pv;

   fwd_clk_pattern_gen #(
      .DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .IDLE_VAL(IDLE_VAL)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .cfg_div(cfg_div),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .d0(d0), .d1(d1),
      .running(running)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_edge();
      bit xfer;
      xfer = cfg_valid && !m_pv;
      if (reset) begin
         m_run = 0; m_slot = 0; m_div = DEF_DIV; m_pv = 0;
      end else if (!m_run) begin
         if (m_pv) begin
            m_div = m_pend; m_pv = 0;
         end else if (cfg_valid) begin
            m_pend = (cfg_div == 0) ? 1 : int'(cfg_div); m_pv = 1;
         end else if (enable) begin
            m_run = 1; m_slot = 0;
         end
      end else begin
         if (m_slot == m_div - 1) begin
            if (m_pv) begin
               m_div = m_pend; m_pv = 0;
            end
            m_slot = 0;
            m_run  = enable;
         end else begin
            m_slot++;
         end
         if (xfer) begin
            m_pend = (cfg_div == 0) ? 1 : int'(cfg_div); m_pv = 1;
         end
      end
   endtask

   task automatic step();
      logic e0, e1;
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      e0 = m_run ? logic'((2 * m_slot) < m_div) : IDLE_VAL;
      e1 = m_run ? logic'((2 * m_slot + 1) < m_div) : IDLE_VAL;
      $display("cyc=%0d rst=%b en=%b cv=%b cd=%0d | d0=%b d1=%b run=%b rdy=%b",
               cyc, reset, enable, cfg_valid, cfg_div, d0, d1, running, cfg_ready);
      chk("model_d0", d0, e0);
      chk("model_d1", d1, e1);
      chk("model_running", running, logic'(m_run));
      chk("model_cfg_ready", cfg_ready, logic'(!m_pv));
   endtask

   // Present a ratio until it is accepted (bounded).
   task automatic do_cfg(input int v);
      logic acc;
      bit done;
      done = 0;
      cfg_div = DIV_W'(v);
      cfg_valid = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         acc = cfg_ready;
         step();
         if (acc) done = 1;
      end
      cfg_valid = 1'b0;
      if (!done) chk("cfg_accept_timeout", 1'b0, 1'b1);
   endtask

   task automatic wait_pair11();
      bit seen;
      seen = (d0 === 1'b1) && (d1 === 1'b1);
      for (int i = 0; i < 20 && !seen; i++) begin
         step();
         seen = (d0 === 1'b1) && (d1 === 1'b1);
      end
      if (!seen) chk("pair11_timeout", 1'b0, 1'b1);
   endtask

   initial begin
      logic [1:0] pat3 [3];
      bit ok;
      pat3[0] = 2'b11; pat3[1] = 2'b10; pat3[2] = 2'b00;

      // Reset with enable held high, then free-running div=1.
      reset = 1'b1; enable = 1'b1;
      repeat (3) step();
      chk("reset_d0", d0, IDLE_VAL);
      chk("reset_d1", d1, IDLE_VAL);
      chk("reset_running", running, 1'b0);
      chk("reset_cfg_ready", cfg_ready, 1'b1);
      reset = 1'b0;
      step();
      chk("div1_first_d0", d0, 1'b1);
      chk("div1_first_d1", d1, 1'b0);
      repeat (7) step();
      chk("div1_d0", d0, 1'b1);
      chk("div1_d1", d1, 1'b0);
      chk("div1_running", running, 1'b1);

      // Stop, configure div=3 in idle, then start.
      enable = 1'b0;
      repeat (2) step();
      chk("stopped_running", running, 1'b0);
      do_cfg(3);
      chk("idle_cfg_busy", cfg_ready, 1'b0);
      step();
      chk("idle_cfg_done", cfg_ready, 1'b1);
      enable = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         chk("div3_d0", d0, pat3[k % 3][1]);
         chk("div3_d1", d1, pat3[k % 3][0]);
      end

      // Drop enable during the (1,1) pair; the period completes.
      wait_pair11();
      enable = 1'b0;
      step();
      chk("drain1_d0", d0, 1'b1); chk("drain1_d1", d1, 1'b0); chk("drain1_run", running, 1'b1);
      step();
      chk("drain2_d0", d0, 1'b0); chk("drain2_d1", d1, 1'b0); chk("drain2_run", running, 1'b1);
      step();
      chk("drain3_d0", d0, IDLE_VAL); chk("drain3_run", running, 1'b0);

      // div=2 running, div=5 requested mid-period.
      do_cfg(2);
      step();
      enable = 1'b1;
      repeat (4) step();
      do_cfg(5);
      chk("midrun_cfg_busy", cfg_ready, 1'b0);
      ok = (cfg_ready === 1'b1);
      for (int i = 0; i < 20 && !ok; i++) begin
         step();
         ok = (cfg_ready === 1'b1);
      end
      if (!ok) chk("apply5_timeout", 1'b0, 1'b1);
      repeat (12) step();

      // cfg_div=0 behaves as div=1.
      do_cfg(0);
      repeat (12) step();
      for (int k = 0; k < 4; k++) begin
         step();
         chk("div0_d0", d0, 1'b1);
         chk("div0_d1", d1, 1'b0);
      end

      // Reset during the (1,1) pair of div=4.
      do_cfg(4);
      repeat (10) step();
      wait_pair11();
      reset = 1'b1;
      step();
      chk("midreset_d0", d0, IDLE_VAL);
      chk("midreset_d1", d1, IDLE_VAL);
      chk("midreset_running", running, 1'b0);
      chk("midreset_cfg_ready", cfg_ready, 1'b1);
      reset = 1'b0;
      step();
      chk("postreset_def_d0", d0, 1'b1);
      chk("postreset_def_d1", d1, 1'b0);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) < 8) enable = ~enable;
         cfg_valid = ($urandom_range(0, 99) < 15);
         cfg_div = DIV_W'($urandom_range(0, 6));
         reset = ($urandom_range(0, 199) == 0);
         step();
      end
      reset = 1'b0; cfg_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
